// File: rtl/comp_layer_ctrl_pkg.sv
// Shared definitions for the argmax comparison-layer controller: default sizing
// and the controller state codes that other layer controllers reuse.
package comp_layer_ctrl_pkg;

    localparam int N_DEF        = 10;
    localparam int CHAR_NUM_DEF = 200;
    localparam int N_LEN_DEF    = 16;
    localparam int CHAR_LEN_DEF = 8;
    localparam int TIMEOUT_DEF  = 1023;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_OUT   = 3'd2,
        ST_REARM = 3'd3,
        ST_ERR   = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/comp_layer_ctrl.sv
// Sequencer for the argmax comparison layer: accepts a score frame, runs the
// layer under a watchdog, captures indices/max values and hands them downstream.
module comp_layer_ctrl
    import comp_layer_ctrl_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int CHAR_NUM = CHAR_NUM_DEF,
    parameter int N_LEN    = N_LEN_DEF,
    parameter int CHAR_LEN = CHAR_LEN_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*CHAR_NUM*N_LEN-1:0]  in_data,
    output logic                         comp_run,
    output logic [N*CHAR_NUM*N_LEN-1:0]  comp_d,
    input  logic                         comp_valid,
    input  logic [N*CHAR_LEN-1:0]        comp_num,
    input  logic [N*N_LEN-1:0]           comp_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N*CHAR_LEN-1:0]        out_num,
    output logic [N*N_LEN-1:0]           out_q,
    output logic                         busy,
    output logic                         err_timeout,
    input  logic                         clr_err,
    output logic [15:0]                  batch_cnt
);

    localparam int FRAME_W = N*CHAR_NUM*N_LEN;
    localparam int TW      = $clog2(TIMEOUT+1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT-1);

    ctrl_state_t        state_reg, state_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic               comp_run_reg, comp_run_next;
    logic               out_valid_reg, out_valid_next;
    logic               err_reg, err_next;
    logic [15:0]        batch_cnt_reg, batch_cnt_next;
    logic [FRAME_W-1:0] comp_d_reg;
    logic               load_frame;
    logic               capture;

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        comp_run_next  = comp_run_reg;
        out_valid_next = out_valid_reg;
        err_next       = err_reg;
        batch_cnt_next = batch_cnt_reg;
        load_frame     = 1'b0;
        capture        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    load_frame    = 1'b1;
                    timer_next    = '0;
                    comp_run_next = 1'b1;
                    state_next    = ST_RUN;
                end
            end
            ST_RUN: begin
                timer_next = timer_reg + 1'b1;
                // A result arriving on the last watchdog cycle still counts.
                if (comp_valid) begin
                    capture        = 1'b1;
                    comp_run_next  = 1'b0;
                    out_valid_next = 1'b1;
                    state_next     = ST_OUT;
                end else if (timer_reg == TIMER_LAST) begin
                    err_next      = 1'b1;
                    comp_run_next = 1'b0;
                    state_next    = ST_ERR;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    batch_cnt_next = batch_cnt_reg + 16'd1;
                    state_next     = ST_REARM;
                end
            end
            ST_REARM: begin
                // Never restart the layer while it still reports the old result.
                if (!comp_valid) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (clr_err) begin
                    err_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            comp_run_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            batch_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            comp_run_reg  <= comp_run_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= err_next;
            batch_cnt_reg <= batch_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_d_reg <= '0;
        end else if (load_frame) begin
            comp_d_reg <= in_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_capture
            logic [CHAR_LEN-1:0] num_reg;
            logic [N_LEN-1:0]    q_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    num_reg <= '0;
                    q_reg   <= '0;
                end else if (capture) begin
                    num_reg <= comp_num[gi*CHAR_LEN +: CHAR_LEN];
                    q_reg   <= comp_q[gi*N_LEN +: N_LEN];
                end
            end
            assign out_num[gi*CHAR_LEN +: CHAR_LEN] = num_reg;
            assign out_q[gi*N_LEN +: N_LEN]         = q_reg;
        end
    endgenerate

    assign in_ready    = (state_reg == ST_IDLE) && !rst;
    assign busy        = (state_reg != ST_IDLE);
    assign comp_run    = comp_run_reg;
    assign comp_d      = comp_d_reg;
    assign out_valid   = out_valid_reg;
    assign err_timeout = err_reg;
    assign batch_cnt   = batch_cnt_reg;

endmodule

// File: tb/tb_comp_layer_ctrl.sv
// Directed bench for comp_layer_ctrl with a behavioural argmax layer model
// (programmable latency, stuck-valid and never-valid modes) and a result scoreboard.
`timescale 1ns/1ps
module tb_comp_layer_ctrl;

    localparam int N        = 10;
    localparam int CHAR_NUM = 200;
    localparam int N_LEN    = 8;
    localparam int CHAR_LEN = 8;
    localparam int TIMEOUT  = 16;
    localparam int FRAME_W  = N*CHAR_NUM*N_LEN;
    localparam int NUM_W    = N*CHAR_LEN;
    localparam int Q_W      = N*N_LEN;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [FRAME_W-1:0] in_data;
    logic               comp_run;
    logic [FRAME_W-1:0] comp_d;
    logic               comp_valid;
    logic [NUM_W-1:0]   comp_num;
    logic [Q_W-1:0]     comp_q;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_W-1:0]   out_num;
    logic [Q_W-1:0]     out_q;
    logic               busy;
    logic               err_timeout;
    logic               clr_err;
    logic [15:0]        batch_cnt;

    comp_layer_ctrl #(
        .N(N), .CHAR_NUM(CHAR_NUM), .N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .comp_run(comp_run), .comp_d(comp_d),
        .comp_valid(comp_valid), .comp_num(comp_num), .comp_q(comp_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num), .out_q(out_q),
        .busy(busy), .err_timeout(err_timeout), .clr_err(clr_err), .batch_cnt(batch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_W-1:0] num;
        logic [Q_W-1:0]   q;
    } exp_t;

    exp_t               sb[$];
    exp_t               exp_e;
    logic [FRAME_W-1:0] frame_v;
    logic [FRAME_W-1:0] f1;
    int vectors     = 0;
    int miscompares = 0;
    int n_out       = 0;
    int viol        = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural comparison layer ----------------
    int lat   = 3;
    int stuck = 0;
    bit never = 1'b0;
    int run_cnt;
    int stuck_left;

    always @(posedge clk or posedge rst) begin : layer_model
        logic [N_LEN-1:0]  best;
        logic [N_LEN-1:0]  v;
        int                bi;
        if (rst) begin
            run_cnt    <= 0;
            stuck_left <= 0;
            comp_valid <= 1'b0;
            comp_num   <= '0;
            comp_q     <= '0;
        end else if (comp_run) begin
            if (run_cnt == 0) begin
                for (int c = 0; c < N; c++) begin
                    best = '0;
                    bi   = 0;
                    for (int k = 0; k < CHAR_NUM; k++) begin
                        v = comp_d[(c*CHAR_NUM+k)*N_LEN +: N_LEN];
                        if (v > best) begin
                            best = v;
                            bi   = k;
                        end
                    end
                    comp_num[c*CHAR_LEN +: CHAR_LEN] <= CHAR_LEN'(bi);
                    comp_q[c*N_LEN +: N_LEN]         <= best;
                end
            end
            run_cnt <= run_cnt + 1;
            if (!never && run_cnt == lat-1) begin
                comp_valid <= 1'b1;
                stuck_left <= stuck;
            end
        end else begin
            run_cnt <= 0;
            if (comp_valid) begin
                if (stuck_left > 0) stuck_left <= stuck_left - 1;
                else                comp_valid <= 1'b0;
            end
        end
    end

    // ---------------- output scoreboard and run-start monitor ----------------
    bit prev_run = 1'b0;
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("sb_size", 128'(sb.size()), 128'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("out_num", 128'(out_num), 128'(e.num));
                check_val("out_q", 128'(out_q), 128'(e.q));
                $display("result %0d: out_num=%0h out_q=%0h batch_cnt=%0d", n_out, out_num, out_q, batch_cnt);
                n_out++;
            end
        end
        if (comp_run && !prev_run && comp_valid) viol++;
        prev_run = comp_run;
    end

    // ---------------- stimulus helpers ----------------
    task automatic build_frame(input int idx0, input int idx9);
        int idx;
        logic [N_LEN-1:0] val;
        for (int c = 0; c < N; c++) begin
            if (c == 0 && idx0 >= 0)          idx = idx0;
            else if (c == N-1 && idx9 >= 0)   idx = idx9;
            else                              idx = $urandom_range(CHAR_NUM-1, 0);
            val = N_LEN'(245 + $urandom_range(10, 0));
            for (int k = 0; k < CHAR_NUM; k++) begin
                frame_v[(c*CHAR_NUM+k)*N_LEN +: N_LEN] = (k == idx) ? val : N_LEN'($urandom_range(240, 0));
            end
            exp_e.num[c*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(idx);
            exp_e.q[c*N_LEN +: N_LEN]         = val;
        end
    endtask

    // Called at a negedge; returns at the first negedge after the accepting edge.
    task automatic send_frame(input bit expect_result);
        bit ok;
        in_data  = frame_v;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_val("accept_wait", 128'(in_ready), 128'd1);
        @(posedge clk);
        if (ok && expect_result) sb.push_back(exp_e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string tag, inout int k);
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) check_val(tag, 128'(out_valid), 128'd1);
    endtask

    task automatic wait_idle(input string tag, inout int k);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) check_val(tag, 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int  k;
        int  b0;
        bit  stable;
        bit  rdy_seen;
        logic [NUM_W-1:0] snap_num;
        logic [Q_W-1:0]   snap_q;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_comp_run", 128'(comp_run), 128'd0);
        check_val("rst_out_valid", 128'(out_valid), 128'd0);
        check_val("rst_busy", 128'(busy), 128'd0);
        check_val("rst_err", 128'(err_timeout), 128'd0);
        check_val("rst_batch", 128'(batch_cnt), 128'd0);
        check_val("rst_in_ready", 128'(in_ready), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("in_ready_after_rst", 128'(in_ready), 128'd1);

        // Single frame, L=3, consumer always ready
        lat = 3;
        build_frame(17, 199);
        send_frame(1'b1);
        check_val("run_rise", 128'(comp_run), 128'd1);
        k = 1;
        wait_out_valid("wait_out1", k);
        check_val("latency_l3", 128'(k), 128'(lat + 2));
        check_val("num_char0", 128'(out_num[0 +: CHAR_LEN]), 128'd17);
        check_val("num_char9", 128'(out_num[9*CHAR_LEN +: CHAR_LEN]), 128'd199);
        wait_idle("wait_idle1", k);
        check_val("busy_drop", 128'(k <= lat + 5), 128'd1);
        check_val("batch_1", 128'(batch_cnt), 128'd1);

        // Backpressure with a second frame offered while busy
        out_ready = 1'b0;
        build_frame(-1, -1);
        f1 = frame_v;
        send_frame(1'b1);
        k = 1;
        wait_out_valid("wait_out_bp", k);
        snap_num = out_num;
        snap_q   = out_q;
        b0       = int'(batch_cnt);
        in_data  = ~f1;
        in_valid = 1'b1;
        stable   = 1'b1;
        rdy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_num !== snap_num || out_q !== snap_q) stable = 1'b0;
            if (in_ready) rdy_seen = 1'b1;
        end
        check_val("bp_hold", 128'(stable), 128'd1);
        check_val("bp_in_ready", 128'(rdy_seen), 128'd0);
        check_val("bp_comp_d", 128'(comp_d == f1), 128'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        wait_idle("wait_idle_bp", k);
        check_val("bp_batch", 128'(batch_cnt), 128'(b0 + 1));

        // Watchdog: layer never answers
        never = 1'b1;
        build_frame(-1, -1);
        send_frame(1'b0);
        k = 0;
        while (!err_timeout && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("timeout_cycles", 128'(k), 128'(TIMEOUT));
        check_val("err_comp_run", 128'(comp_run), 128'd0);
        check_val("err_in_ready", 128'(in_ready), 128'd0);
        check_val("err_out_valid", 128'(out_valid), 128'd0);
        repeat (3) @(negedge clk);
        check_val("err_sticky", 128'(err_timeout), 128'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_val("clr_in_ready", 128'(in_ready), 128'd1);
        check_val("clr_err", 128'(err_timeout), 128'd0);
        never = 1'b0;

        // Result arrives on the last watchdog cycle
        lat = TIMEOUT - 1;
        build_frame(-1, -1);
        send_frame(1'b1);
        k = 1;
        wait_out_valid("wait_out_edge", k);
        check_val("edge_latency", 128'(k), 128'(lat + 2));
        check_val("edge_err", 128'(err_timeout), 128'd0);
        k = 0;
        wait_idle("wait_idle_edge", k);

        // Layer holds valid after run drops
        lat = 2; stuck = 5;
        build_frame(-1, -1);
        send_frame(1'b1);
        k = 1;
        wait_out_valid("wait_out_stuck", k);
        k = 0;
        while (comp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("stuck_rearm", 128'(in_ready), 128'd0);
        @(negedge clk);
        check_val("stuck_release", 128'(in_ready), 128'd1);
        stuck = 0;
        build_frame(-1, -1);
        send_frame(1'b1);
        k = 0;
        wait_idle("wait_idle_after_stuck", k);

        // Asynchronous reset in the middle of RUN
        lat = 10;
        build_frame(-1, -1);
        send_frame(1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_run", 128'(comp_run), 128'd0);
        check_val("mid_rst_busy", 128'(busy), 128'd0);
        check_val("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check_val("mid_rst_batch", 128'(batch_cnt), 128'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lat = 3;
        build_frame(-1, -1);
        send_frame(1'b1);
        k = 0;
        wait_idle("wait_idle_post_rst", k);
        check_val("post_rst_batch", 128'(batch_cnt), 128'd1);

        // Batch counter wrap
        @(negedge clk);
        force dut.batch_cnt_reg = 16'hFFFF;
        @(negedge clk);
        release dut.batch_cnt_reg;
        @(negedge clk);
        check_val("preload", 128'(batch_cnt), 128'hFFFF);
        build_frame(-1, -1);
        send_frame(1'b1);
        k = 0;
        wait_idle("wait_idle_wrap", k);
        check_val("wrap", 128'(batch_cnt), 128'd0);

        repeat (2) @(negedge clk);
        check_val("run_while_valid", 128'(viol), 128'd0);
        check_val("sb_drained", 128'(sb.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
